// File: rtl/dmem_access_ctrl_if.sv
// Data-memory bus between the Memory-stage access controller (master) and the memory (slave).
// Handshake: the master raises mem_req with mem_we/mem_addr/mem_wdata/mem_be stable and holds
// them until the slave returns a one-cycle mem_ack; mem_rdata is only meaningful with mem_ack.
interface dmem_access_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Memory-stage load/store controller: registered req/ack bus cycle, pipeline stall, load align/extend.
// Optional bus watchdog enabled with `define MEM_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        BubbleW,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic [1:0]  state_o,
    dmem_access_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  off_q, off_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic        req_q, req_d;
    logic [31:0] rdata_q, rdata_d;
    logic        stall, misalign;

    logic        access, is_byte, is_half, is_word, misaligned;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;

    assign access     = MemReadM | MemWriteM;
    assign is_byte    = (Funct3M[1:0] == 2'b00);
    assign is_half    = (Funct3M[1:0] == 2'b01);
    assign is_word    = Funct3M[1];
    assign misaligned = (is_half & ALUResultM[0]) | (is_word & (|ALUResultM[1:0]));

    // Store data is replicated into every lane so the byte enables alone pick the target bytes.
    always_comb begin
        be_n    = 4'b1111;
        wdata_n = WriteDataM;
        if (is_byte) begin
            be_n    = 4'b0001 << ALUResultM[1:0];
            wdata_n = {4{WriteDataM[7:0]}};
        end else if (is_half) begin
            be_n    = 4'b0011 << ALUResultM[1:0];
            wdata_n = {2{WriteDataM[15:0]}};
        end
    end

    function automatic logic [31:0] align_load(input logic [31:0] w, input logic [1:0] off,
                                               input logic [2:0] f3);
        logic [31:0] sh;
        sh = w >> {off, 3'b000};
        case (f3[1:0])
            2'b00:   return {{24{~f3[2] & sh[7]}}, sh[7:0]};
            2'b01:   return {{16{~f3[2] & sh[15]}}, sh[15:0]};
            default: return w;
        endcase
    endfunction

`ifdef MEM_TIMEOUT_EN
    localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout;
    logic            bus_err_q, bus_err_d;

    // Counter is held at zero outside WAIT, so it restarts on every entry.
    assign cnt_d   = (state_q == WAIT) ? cnt_q + CntW'(1) : '0;
    assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
    assign BusErrM = bus_err_q;
`else
    assign BusErrM = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        off_d    = off_q;
        we_d     = we_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        f3_d     = f3_q;
        req_d    = req_q;
        rdata_d  = rdata_q;
        stall    = 1'b0;
        misalign = 1'b0;
`ifdef MEM_TIMEOUT_EN
        bus_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        misalign = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        addr_d  = {ALUResultM[31:2], 2'b00};
                        off_d   = ALUResultM[1:0];
                        we_d    = MemWriteM;
                        be_d    = be_n;
                        wdata_d = wdata_n;
                        f3_d    = Funct3M;
                        req_d   = 1'b1;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (bus.mem_ack) begin
                    rdata_d = align_load(bus.mem_rdata, off_q, f3_q);
                    req_d   = 1'b0;
                    state_d = DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (timeout) begin
                    rdata_d   = '0;
                    req_d     = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = DONE;
                end
`endif
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            off_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            req_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end
`endif

    // Combinational pipeline controls are forced low while reset is held.
    assign StallM        = stall & reset_n;
    assign BubbleW       = stall & reset_n;
    assign MisalignM     = misalign & reset_n;
    assign ReadDataM     = rdata_q;
    assign state_o       = state_q;
    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_be    = be_q;

endmodule
